// File: rtl/mem_ctrl.sv
// Initiator side of the 512x32 RAM port: one load/store at a time,
// registered strobes with address setup/hold, MDR-style read capture.
module mem_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 512,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, HOLD
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             op;
  logic             op_nx;
  logic             accept;
  logic             oob;
  logic             busy_d;
  logic             done_d;
  logic             read_d;
  logic             write_d;
  logic             capture;

  assign accept = (state == IDLE) && start;
  assign oob    = {{(32-ADDR_W){1'b0}}, addr_in} >= 32'(MEM_DEPTH);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = oob ? HOLD : SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop cleanly.
  always_comb begin
    op_nx   = accept ? rw : op;
    busy_d  = state_nx != IDLE;
    done_d  = state_nx == HOLD;
    write_d = (state_nx == ACCESS) && op_nx;
    read_d  = (state_nx == ACCESS) && !op_nx;
    capture = (state == ACCESS) && (state_nx == HOLD) && !op;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state     <= state_nx;
      op        <= op_nx;
      busy      <= busy_d;
      done      <= done_d;
      mem_read  <= read_d;
      mem_write <= write_d;
      if (accept) begin
        mem_addr  <= addr_in;
        mem_wdata <= wdata;
        err       <= oob;
      end
      if (state_nx == ACCESS && state != ACCESS)
        cnt <= CNT_INIT;
      else if (state == ACCESS && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (capture)
        rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances cover the default,
// a stretched-strobe and a reduced-depth configuration.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        rw = 1'b0;
  logic [8:0]  addr_in = '0;
  logic [31:0] wdata = '0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;

  logic        busy0, done0, err0, rd0, wr0;
  logic [31:0] rdata0, mwd0, mrd0;
  logic [8:0]  ma0;
  logic        busy1, done1, err1, rd1, wr1;
  logic [31:0] rdata1, mwd1, mrd1;
  logic [8:0]  ma1;
  logic        busy2, done2, err2, rd2, wr2;
  logic [31:0] rdata2, mwd2, mrd2;
  logic [8:0]  ma2;

  logic [31:0] ram0 [512];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr0) ram0[ma0] <= mwd0;
  assign mrd0 = ram0[ma0];
  assign mrd1 = 32'h0;
  assign mrd2 = 32'hCAFE0000 | {23'h0, ma2};

  mem_ctrl #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .clear_n(clear_n), .start(start0), .rw(rw),
    .addr_in(addr_in), .wdata(wdata), .busy(busy0), .done(done0),
    .err(err0), .rdata(rdata0), .mem_addr(ma0), .mem_read(rd0),
    .mem_write(wr0), .mem_wdata(mwd0), .mem_rdata(mrd0));

  mem_ctrl #(.WAIT_CYCLES(2)) u1 (
    .clk(clk), .clear_n(clear_n), .start(start1), .rw(rw),
    .addr_in(addr_in), .wdata(wdata), .busy(busy1), .done(done1),
    .err(err1), .rdata(rdata1), .mem_addr(ma1), .mem_read(rd1),
    .mem_write(wr1), .mem_wdata(mwd1), .mem_rdata(mrd1));

  mem_ctrl #(.MEM_DEPTH(256)) u2 (
    .clk(clk), .clear_n(clear_n), .start(start2), .rw(rw),
    .addr_in(addr_in), .wdata(wdata), .busy(busy2), .done(done2),
    .err(err2), .rdata(rdata2), .mem_addr(ma2), .mem_read(rd2),
    .mem_write(wr2), .mem_wdata(mwd2), .mem_rdata(mrd2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({busy0, done0, err0, rd0, wr0} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_u0 flags got %b want 00000",
               {busy0, done0, err0, rd0, wr0});
    end
    vectors++;
    if (rdata0 !== 32'h0 || ma0 !== 9'h0 || mwd0 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_u0 regs rdata=%h addr=%h wd=%h want 0",
               rdata0, ma0, mwd0);
    end
    vectors++;
    if ({busy1, wr1, rd1, busy2, err2, rd2} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_u1u2 got %b want 000000",
               {busy1, wr1, rd1, busy2, err2, rd2});
    end
    @(negedge clk);
    clear_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_store;
    logic [7:0] wm, dm, bm;
    logic       ok;
    ok = 1'b1;
    rw = 1'b1; addr_in = 9'h010; wdata = 32'hDEADBEEF;
    start0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start0 = 1'b0;
      wm[i] = wr0; dm[i] = done0; bm[i] = busy0;
      if (wr0 && (ma0 !== 9'h010 || mwd0 !== 32'hDEADBEEF)) ok = 1'b0;
      if (rd0) ok = 1'b0;
    end
    vectors++;
    if (wm !== 8'b0000_0010) begin
      miscompares++;
      $display("FAIL store_write_mask got %b want 00000010", wm);
    end
    vectors++;
    if (dm !== 8'b0000_0100) begin
      miscompares++;
      $display("FAIL store_done_mask got %b want 00000100", dm);
    end
    vectors++;
    if (bm !== 8'b0000_0111) begin
      miscompares++;
      $display("FAIL store_busy_mask got %b want 00000111", bm);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL store_bus addr/data wrong or read seen ok=%b want 1", ok);
    end
  endtask

  task automatic test_load;
    logic [7:0]  rm, dm;
    logic [31:0] at_done;
    logic        both;
    at_done = 32'hX; both = 1'b0;
    rw = 1'b0; addr_in = 9'h010; wdata = 32'h0;
    start0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start0 = 1'b0;
      rm[i] = rd0; dm[i] = done0;
      if (done0) at_done = rdata0;
      if (rd0 && wr0) both = 1'b1;
    end
    vectors++;
    if (rm !== 8'b0000_0010 || both) begin
      miscompares++;
      $display("FAIL load_read_mask got %b both=%b want 00000010 0", rm, both);
    end
    vectors++;
    if (dm !== 8'b0000_0100) begin
      miscompares++;
      $display("FAIL load_done_mask got %b want 00000100", dm);
    end
    vectors++;
    if (at_done !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL load_rdata_at_done got %h want deadbeef", at_done);
    end
    repeat (10) tick();
    vectors++;
    if (rdata0 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL load_rdata_hold got %h want deadbeef", rdata0);
    end
  endtask

  task automatic test_wait_cycles;
    logic [9:0] wm, dm;
    rw = 1'b1; addr_in = 9'h1FF; wdata = 32'h12345678;
    start1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      wm[i] = wr1; dm[i] = done1;
      start1 = (i == 1 || i == 3 || i == 4);
    end
    start1 = 1'b0;
    vectors++;
    if (wm !== 10'b00_0000_1110) begin
      miscompares++;
      $display("FAIL wait_write_mask got %b want 0000001110", wm);
    end
    vectors++;
    if (dm !== 10'b00_0001_0000) begin
      miscompares++;
      $display("FAIL wait_done_mask got %b want 0000010000", dm);
    end
    vectors++;
    if (ma1 !== 9'h1FF || mwd1 !== 32'h12345678 || rd1 !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_bus addr=%h wd=%h rd=%b want 1ff 12345678 0",
               ma1, mwd1, rd1);
    end
    repeat (3) tick();
  endtask

  task automatic test_range_error;
    logic strobes;
    logic [5:0] dm, bm;
    strobes = 1'b0;
    rw = 1'b0; addr_in = 9'h020;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (4) tick();
    vectors++;
    if (rdata2 !== 32'hCAFE0020 || err2 !== 1'b0) begin
      miscompares++;
      $display("FAIL range_inload rdata=%h err=%b want cafe0020 0",
               rdata2, err2);
    end
    addr_in = 9'h100;
    start2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start2 = 1'b0;
      dm[i] = done2; bm[i] = busy2;
      if (rd2 || wr2) strobes = 1'b1;
      if (i == 0) begin
        vectors++;
        if (err2 !== 1'b1) begin
          miscompares++;
          $display("FAIL range_err got %b want 1", err2);
        end
      end
    end
    vectors++;
    if (dm !== 6'b00_0001 || bm !== 6'b00_0001) begin
      miscompares++;
      $display("FAIL range_done_busy got %b/%b want 000001/000001", dm, bm);
    end
    vectors++;
    if (strobes || rdata2 !== 32'hCAFE0020) begin
      miscompares++;
      $display("FAIL range_side strobes=%b rdata=%h want 0 cafe0020",
               strobes, rdata2);
    end
    addr_in = 9'h020;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    vectors++;
    if (err2 !== 1'b0) begin
      miscompares++;
      $display("FAIL range_err_clear got %b want 0", err2);
    end
    repeat (4) tick();
  endtask

  task automatic test_abort;
    rw = 1'b1; addr_in = 9'h030; wdata = 32'hA5A5A5A5;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    vectors++;
    if (wr0 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre write got %b want 1", wr0);
    end
    #2 clear_n = 1'b0;
    #1;
    vectors++;
    if ({wr0, rd0, busy0, done0} !== 4'b0 || rdata0 !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_async flags=%b rdata=%h want 0000 0",
               {wr0, rd0, busy0, done0}, rdata0);
    end
    @(negedge clk);
    clear_n = 1'b1;
    tick();
    vectors++;
    if ({wr0, rd0, busy0} !== 3'b0) begin
      miscompares++;
      $display("FAIL abort_idle flags=%b want 000", {wr0, rd0, busy0});
    end
    wdata = 32'h0BADCAFE; addr_in = 9'h040;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    rw = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    vectors++;
    if (rdata0 !== 32'h0BADCAFE || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_recover rdata=%h err=%b want 0badcafe 0",
               rdata0, err0);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wait_cycles();
    test_range_error();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
